// File: rtl/servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
// Pulse widths and the frame counter are all carried in whole microseconds.
package servo_pkg;

    localparam int unsigned US_W           = 16;
    localparam int unsigned DEFAULT_MIN_US = 1000;
    localparam int unsigned DEFAULT_MAX_US = 2000;
    localparam int unsigned DEFAULT_US     = (DEFAULT_MIN_US + DEFAULT_MAX_US) / 2;

    // Control registers sit directly above the NUM_CH target words.
    localparam int unsigned OFS_ENABLE = 0;
    localparam int unsigned OFS_SLEW   = 1;
    localparam int unsigned OFS_STATUS = 2;

    function automatic logic [US_W-1:0] clamp_us(
        input logic [US_W-1:0] value,
        input logic [US_W-1:0] min_us,
        input logic [US_W-1:0] max_us
    );
        logic [US_W-1:0] result;
        result = value;
        if (value < min_us) begin
            result = min_us;
        end else if (value > max_us) begin
            result = max_us;
        end
        return result;
    endfunction

endpackage

// File: rtl/servo_slew_ch.sv
// One servo channel: clamped target register, slew-limited current width stepped once per
// frame, and the registered pulse compare against the shared microsecond counter.
module servo_slew_ch
    import servo_pkg::*;
#(
    parameter int unsigned MIN_US = DEFAULT_MIN_US,
    parameter int unsigned MAX_US = DEFAULT_MAX_US
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            frame_start_i,
    input  logic [US_W-1:0] us_cnt_i,
    input  logic            enable_i,
    input  logic [US_W-1:0] slew_i,
    input  logic            wr_en_i,
    input  logic [US_W-1:0] wr_data_i,
    output logic            pwm_o,
    output logic            busy_o,
    output logic [US_W-1:0] target_o
);

    localparam logic [US_W-1:0] LoUs    = US_W'(MIN_US);
    localparam logic [US_W-1:0] HiUs    = US_W'(MAX_US);
    localparam logic [US_W-1:0] ResetUs = US_W'((MIN_US + MAX_US) / 2);

    logic [US_W-1:0] target_q, target_d;
    logic [US_W-1:0] current_q, current_d;
    logic            pwm_q, pwm_d;
    logic [US_W-1:0] diff;
    logic [US_W-1:0] step;

    always_comb begin
        target_d = target_q;
        if (wr_en_i) begin
            target_d = clamp_us(wr_data_i, LoUs, HiUs);
        end
    end

    // The step reads target_q, so a write landing on the frame_start cycle waits a frame.
    always_comb begin
        current_d = current_q;
        diff      = (target_q > current_q) ? (target_q - current_q) : (current_q - target_q);
        step      = (diff < slew_i) ? diff : slew_i;
        if (frame_start_i) begin
            if (slew_i == '0) begin
                current_d = target_q;
            end else if (target_q > current_q) begin
                current_d = current_q + step;
            end else begin
                current_d = current_q - step;
            end
        end
    end

    assign pwm_d = enable_i && (us_cnt_i < current_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            target_q  <= ResetUs;
            current_q <= ResetUs;
            pwm_q     <= 1'b0;
        end else begin
            target_q  <= target_d;
            current_q <= current_d;
            pwm_q     <= pwm_d;
        end
    end

    assign pwm_o    = pwm_q;
    assign busy_o   = (current_q != target_q);
    assign target_o = target_q;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel hobby-servo PWM: shared microsecond frame timer, per-channel slew-limited
// pulse widths and an Avalon-MM register slave for the HPS.
module servo_pwm_multi
    import servo_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned PERIOD_US = 20000,
    parameter int unsigned MIN_US    = DEFAULT_MIN_US,
    parameter int unsigned MAX_US    = DEFAULT_MAX_US,
    parameter int unsigned ADDR_W    = 3
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_start
);

    localparam int unsigned       Presc      = CLK_HZ / 1_000_000;
    localparam int unsigned       PrescW     = $clog2(Presc);
    localparam logic [PrescW-1:0] PrescLast  = PrescW'(Presc - 1);
    localparam logic [US_W-1:0]   UsLast     = US_W'(PERIOD_US - 1);
    localparam logic [ADDR_W-1:0] AddrEnable = ADDR_W'(NUM_CH + OFS_ENABLE);
    localparam logic [ADDR_W-1:0] AddrSlew   = ADDR_W'(NUM_CH + OFS_SLEW);
    localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(NUM_CH + OFS_STATUS);

    logic [PrescW-1:0] presc_q, presc_d;
    logic [US_W-1:0]   us_cnt_q, us_cnt_d;
    logic              frame_start_q, frame_start_d;
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [US_W-1:0]   slew_q, slew_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              us_tick;

    logic [NUM_CH-1:0] wr_target;
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] busy;
    logic [US_W-1:0]   target [NUM_CH];

    logic unused_wdata;
    assign unused_wdata = ^avs_writedata[31:US_W];

    always_comb begin
        us_tick       = (presc_q == PrescLast);
        presc_d       = us_tick ? '0 : presc_q + 1'b1;
        us_cnt_d      = us_cnt_q;
        frame_start_d = 1'b0;
        if (us_tick) begin
            if (us_cnt_q == UsLast) begin
                us_cnt_d      = '0;
                frame_start_d = 1'b1;
            end else begin
                us_cnt_d = us_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        enable_d = enable_q;
        slew_d   = slew_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            wr_target[ch] = avs_write && (avs_address == ADDR_W'(ch));
        end
        if (avs_write && (avs_address == AddrEnable)) begin
            enable_d = avs_writedata[NUM_CH-1:0];
        end
        if (avs_write && (avs_address == AddrSlew)) begin
            slew_d = avs_writedata[US_W-1:0];
        end
    end

    // Read data comes from the registered state, so a same-cycle write is not yet visible.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_read) begin
            rdata_d = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (avs_address == ADDR_W'(ch)) begin
                    rdata_d = {{(32 - US_W){1'b0}}, target[ch]};
                end
            end
            if (avs_address == AddrEnable) begin
                rdata_d = 32'(enable_q);
            end
            if (avs_address == AddrSlew) begin
                rdata_d = {{(32 - US_W){1'b0}}, slew_q};
            end
            if (avs_address == AddrStatus) begin
                rdata_d = {us_cnt_q, US_W'(busy)};
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            presc_q       <= '0;
            us_cnt_q      <= '0;
            frame_start_q <= 1'b0;
            enable_q      <= '0;
            slew_q        <= '0;
            rdata_q       <= '0;
        end else begin
            presc_q       <= presc_d;
            us_cnt_q      <= us_cnt_d;
            frame_start_q <= frame_start_d;
            enable_q      <= enable_d;
            slew_q        <= slew_d;
            rdata_q       <= rdata_d;
        end
    end

    // Channels see the next-state enable so a disable cuts the pulse on the commit edge.
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        servo_slew_ch #(
            .MIN_US (MIN_US),
            .MAX_US (MAX_US)
        ) u_ch (
            .clk_i         (iCLK),
            .rst_ni        (iRST_N),
            .frame_start_i (frame_start_q),
            .us_cnt_i      (us_cnt_q),
            .enable_i      (enable_d[ch]),
            .slew_i        (slew_q),
            .wr_en_i       (wr_target[ch]),
            .wr_data_i     (avs_writedata[US_W-1:0]),
            .pwm_o         (pwm[ch]),
            .busy_o        (busy[ch]),
            .target_o      (target[ch])
        );
    end

    assign pwm_out      = pwm;
    assign frame_start  = frame_start_q;
    assign avs_readdata = rdata_q;

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi at reduced timing: 2 clocks per us, 100 us frame, 10..90 us clamp.
module tb_servo_pwm_multi;

    localparam int NCH       = 4;
    localparam int PRESC     = 2;
    localparam int PER       = 100;
    localparam int LO        = 10;
    localparam int HI        = 90;
    localparam int MID       = (LO + HI) / 2;
    localparam int FRAME_CYC = PER * PRESC;
    localparam int A_EN      = 4;
    localparam int A_SLEW    = 5;
    localparam int A_STATUS  = 6;
    localparam int A_NONE    = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [2:0]     avs_address = '0;
    logic           avs_write = 1'b0;
    logic [31:0]    avs_writedata = '0;
    logic           avs_read = 1'b0;
    logic [31:0]    avs_readdata;
    logic [NCH-1:0] pwm_out;
    logic           frame_start;

    servo_pwm_multi #(
        .NUM_CH    (NCH),
        .CLK_HZ    (2_000_000),
        .PERIOD_US (PER),
        .MIN_US    (LO),
        .MAX_US    (HI),
        .ADDR_W    (3)
    ) dut (
        .iCLK          (clk),
        .iRST_N        (rst_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .pwm_out       (pwm_out),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: register contents and per-channel current width in us.
    int             m_tgt [NCH];
    int             m_cur [NCH];
    logic [NCH-1:0] m_en;
    int             m_slew;

    int             meas [NCH];
    int             exp_w [NCH];
    logic [NCH-1:0] exp_busy;
    logic [31:0]    meas_status;

    function automatic int clampv(input logic [31:0] v);
        int x;
        x = int'(v[15:0]);
        if (x < LO) return LO;
        if (x > HI) return HI;
        return x;
    endfunction

    function automatic int slew_step(input int tgt, input int cur, input int slew);
        if (slew == 0) return tgt;
        if (tgt > cur) return (tgt - cur > slew) ? cur + slew : tgt;
        return (cur - tgt > slew) ? cur - slew : tgt;
    endfunction

    always @(negedge clk) begin
        for (int ch = 0; ch < NCH; ch++) begin
            if (!rst_n) m_cur[ch] <= MID;
            else if (frame_start === 1'b1) m_cur[ch] <= slew_step(m_tgt[ch], m_cur[ch], m_slew);
        end
    end

    task automatic model_regs_reset();
        for (int ch = 0; ch < NCH; ch++) m_tgt[ch] = MID;
        m_en   = '0;
        m_slew = 0;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        if (a < NCH) m_tgt[a] = clampv(d);
        else if (a == A_EN) m_en = d[NCH-1:0];
        else if (a == A_SLEW) m_slew = int'(d[15:0]);
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        @(negedge clk);
        avs_address   = 3'(a);
        avs_writedata = d;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        model_write(a, d);
    endtask

    task automatic do_read(input int a, output logic [31:0] d);
        @(negedge clk);
        avs_address = 3'(a);
        avs_read    = 1'b1;
        @(posedge clk);
        #1;
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wait_fs();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_frame_start: none within %0d cycles, required one", 3 * FRAME_CYC);
        end
    endtask

    // Counts high cycles per channel over one whole frame and grabs STATUS at cycle 20.
    task automatic measure_frame();
        wait_fs();
        #1;
        for (int ch = 0; ch < NCH; ch++) begin
            exp_w[ch]    = m_en[ch] ? PRESC * m_cur[ch] : 0;
            exp_busy[ch] = (m_cur[ch] != m_tgt[ch]);
            meas[ch]     = 0;
        end
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            for (int ch = 0; ch < NCH; ch++) if (pwm_out[ch] === 1'b1) meas[ch]++;
            if (i == 20) begin
                avs_address = 3'(A_STATUS);
                avs_read    = 1'b1;
            end
            if (i == 21) begin
                meas_status = avs_readdata;
                avs_read    = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        model_regs_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm_out !== '0 || frame_start !== 1'b0 || avs_readdata !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: pwm=%b fs=%b rdata=%h, required all zero",
                     pwm_out, frame_start, avs_readdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            do_read(ch, d);
            n_checks++;
            if (d !== 32'(MID)) begin
                n_fail++;
                $display("FAIL reset_target%0d: got %0d, required %0d", ch, d, MID);
            end
        end
        do_read(A_EN, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_enable: got %h, required 0", d);
        end
        do_read(A_SLEW, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_slew: got %h, required 0", d);
        end
        do_read(A_STATUS, d);
        n_checks++;
        if (d[15:0] !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_status_busy: got %h, required 0", d[15:0]);
        end
    endtask

    task automatic test_default_width();
        do_write(A_EN, 32'h1);
        measure_frame();
        for (int ch = 0; ch < NCH; ch++) begin
            n_checks++;
            if (meas[ch] !== exp_w[ch]) begin
                n_fail++;
                $display("FAIL default_width ch%0d: got %0d cycles, required %0d",
                         ch, meas[ch], exp_w[ch]);
            end
        end
        n_checks++;
        if (meas_status[31:16] !== 16'(20 / PRESC)) begin
            n_fail++;
            $display("FAIL status_us_cnt: got %0d, required %0d", meas_status[31:16], 20 / PRESC);
        end
    endtask

    task automatic test_clamp();
        logic [31:0] vals [10];
        logic [31:0] d;
        vals[0] = 32'd5;
        vals[1] = 32'd0;
        vals[2] = 32'hFFFF_0030;
        vals[3] = 32'd90;
        vals[4] = 32'd10;
        vals[5] = 32'h0000_FFFF;
        for (int i = 6; i < 9; i++) vals[i] = $urandom();
        vals[9] = 32'd200;
        for (int i = 0; i < 10; i++) begin
            do_write(0, vals[i]);
            do_read(0, d);
            n_checks++;
            if (d !== 32'(clampv(vals[i]))) begin
                n_fail++;
                $display("FAIL clamp_readback wr=%h: got %0d, required %0d", vals[i], d,
                         clampv(vals[i]));
            end
        end
        measure_frame();
        n_checks++;
        if (meas[0] !== exp_w[0] || exp_w[0] != PRESC * HI) begin
            n_fail++;
            $display("FAIL clamp_width: got %0d cycles, required %0d", meas[0], PRESC * HI);
        end
    endtask

    task automatic test_slew();
        do_write(A_SLEW, 32'd10);
        do_write(1, 32'd80);
        do_write(A_EN, 32'h2);
        for (int f = 0; f < 3; f++) begin
            measure_frame();
            n_checks++;
            if (meas[1] !== exp_w[1]) begin
                n_fail++;
                $display("FAIL slew_width frame%0d: got %0d cycles, required %0d",
                         f, meas[1], exp_w[1]);
            end
            n_checks++;
            if (meas_status[1] !== exp_busy[1]) begin
                n_fail++;
                $display("FAIL slew_busy frame%0d: got %b, required %b",
                         f, meas_status[1], exp_busy[1]);
            end
        end
    endtask

    task automatic test_disable_mid_pulse();
        do_write(A_EN, 32'h1);
        wait_fs();
        repeat (40) @(negedge clk);
        n_checks++;
        if (pwm_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL disable_pre_high: got %b, required 1", pwm_out[0]);
        end
        avs_address   = 3'(A_EN);
        avs_writedata = 32'h0;
        avs_write     = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        model_write(A_EN, 32'h0);
        n_checks++;
        if (pwm_out[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL disable_next_clock: got %b, required 0", pwm_out[0]);
        end
        measure_frame();
        n_checks++;
        if (meas[0] !== 0) begin
            n_fail++;
            $display("FAIL disable_next_frame: got %0d cycles, required 0", meas[0]);
        end
    endtask

    task automatic test_frame_write();
        int    cnt;
        int    exp_old;
        logic [31:0] nv;
        do_write(A_SLEW, 32'd0);
        do_write(2, 32'd30);
        do_write(A_EN, 32'h4);
        measure_frame();
        n_checks++;
        if (meas[2] !== exp_w[2]) begin
            n_fail++;
            $display("FAIL frame_write_setup: got %0d cycles, required %0d", meas[2], exp_w[2]);
        end
        nv = 32'($urandom_range(40, 90));
        wait_fs();
        avs_address   = 3'd2;
        avs_writedata = nv;
        avs_write     = 1'b1;
        #1;
        exp_old = PRESC * m_cur[2];
        cnt     = (pwm_out[2] === 1'b1) ? 1 : 0;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        model_write(2, nv);
        for (int i = 1; i < FRAME_CYC; i++) begin
            @(negedge clk);
            #1;
            if (pwm_out[2] === 1'b1) cnt++;
        end
        n_checks++;
        if (cnt !== exp_old) begin
            n_fail++;
            $display("FAIL frame_write_same_frame: got %0d cycles, required %0d", cnt, exp_old);
        end
        measure_frame();
        n_checks++;
        if (meas[2] !== exp_w[2] || exp_w[2] != PRESC * int'(nv)) begin
            n_fail++;
            $display("FAIL frame_write_next_frame: got %0d cycles, required %0d",
                     meas[2], PRESC * int'(nv));
        end
    endtask

    task automatic test_random_slew();
        logic [31:0] wd;
        for (int r = 0; r < 3; r++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                wd = ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 130));
                do_write(ch, wd);
            end
            do_write(A_SLEW, 32'($urandom_range(0, 25)));
            do_write(A_EN, 32'($urandom_range(1, 15)));
            for (int f = 0; f < 3; f++) begin
                measure_frame();
                for (int ch = 0; ch < NCH; ch++) begin
                    n_checks++;
                    if (meas[ch] !== exp_w[ch]) begin
                        n_fail++;
                        $display("FAIL random_width r%0d f%0d ch%0d: got %0d, required %0d",
                                 r, f, ch, meas[ch], exp_w[ch]);
                    end
                end
                n_checks++;
                if (meas_status[15:0] !== 16'(exp_busy)) begin
                    n_fail++;
                    $display("FAIL random_busy r%0d f%0d: got %h, required %h",
                             r, f, meas_status[15:0], exp_busy);
                end
            end
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] d;
        int old;
        int nv;
        old = m_tgt[0];
        nv  = (old == 20) ? 70 : 20;
        @(negedge clk);
        avs_address   = 3'd0;
        avs_writedata = 32'(nv);
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        @(posedge clk);
        #1;
        avs_write = 1'b0;
        avs_read  = 1'b0;
        d = avs_readdata;
        model_write(0, 32'(nv));
        n_checks++;
        if (d !== 32'(old)) begin
            n_fail++;
            $display("FAIL rw_same_cycle_old: got %0d, required %0d", d, old);
        end
        do_read(0, d);
        n_checks++;
        if (d !== 32'(nv)) begin
            n_fail++;
            $display("FAIL rw_same_cycle_new: got %0d, required %0d", d, nv);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        do_read(A_NONE, d);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %h, required 0", d);
        end
        do_write(A_NONE, $urandom());
        do_write(A_STATUS, $urandom());
        for (int ch = 0; ch < NCH; ch++) begin
            do_read(ch, d);
            n_checks++;
            if (d !== 32'(m_tgt[ch])) begin
                n_fail++;
                $display("FAIL unmapped_write_target%0d: got %0d, required %0d", ch, d, m_tgt[ch]);
            end
        end
        do_read(A_EN, d);
        n_checks++;
        if (d !== 32'(m_en)) begin
            n_fail++;
            $display("FAIL unmapped_write_enable: got %h, required %h", d, m_en);
        end
        do_read(A_SLEW, d);
        n_checks++;
        if (d !== 32'(m_slew)) begin
            n_fail++;
            $display("FAIL unmapped_write_slew: got %0d, required %0d", d, m_slew);
        end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] d;
        int cnt;
        do_write(A_SLEW, 32'd0);
        do_write(0, 32'd60);
        do_write(A_EN, 32'h1);
        measure_frame();
        wait_fs();
        repeat (20) @(negedge clk);
        n_checks++;
        if (pwm_out[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre_high: got %b, required 1", pwm_out[0]);
        end
        #2;
        rst_n = 1'b0;
        model_regs_reset();
        #1;
        n_checks++;
        if (pwm_out !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %b, required 0", pwm_out);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clk);
            cnt++;
            if (frame_start === 1'b1) break;
        end
        n_checks++;
        if (cnt !== FRAME_CYC) begin
            n_fail++;
            $display("FAIL reset_first_frame: got %0d cycles, required %0d", cnt, FRAME_CYC);
        end
        for (int ch = 0; ch < NCH; ch++) begin
            do_read(ch, d);
            n_checks++;
            if (d !== 32'(MID)) begin
                n_fail++;
                $display("FAIL reset_mid_target%0d: got %0d, required %0d", ch, d, MID);
            end
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_default_width();
        test_clamp();
        test_slew();
        test_disable_mid_pulse();
        test_frame_write();
        test_random_slew();
        test_rw_same_cycle();
        test_unmapped();
        test_reset_mid_pulse();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Parametrised successor to the single-channel servo PWM: drives NUM_CH hobby-servo outputs from one shared frame timer.
- Avalon-MM slave in Computer_System, written by the HPS over the lightweight bridge.
- Per-channel pulse width in µs, clamped to a safe range; per-channel enable.
- Programmable slew limiting moves each output gradually toward its target, once per frame.

Parameters:
- NUM_CH, 4, number of servo channels (1..16)
- CLK_HZ, 50_000_000, iCLK frequency; CLK_HZ/1_000_000 must be an integer ≥2
- PERIOD_US, 20000, PWM frame length in µs
- MIN_US, 1000, lower clamp on pulse width
- MAX_US, 2000, upper clamp on pulse width (MAX_US < PERIOD_US)
- ADDR_W, 3, Avalon address width; must satisfy 2^ADDR_W ≥ NUM_CH+3

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- avs_address  in  ADDR_W  register word address
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_read  in  1  read strobe
- avs_readdata  out  32  read data, valid exactly one cycle after avs_read
- pwm_out  out  NUM_CH  servo pulse outputs
- frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- Clocking and reset: one clock, iCLK. Reset is asynchronous, active-low on iRST_N.
- Reset values:
  - pwm_out=0, frame_start=0, avs_readdata=0.
  - All targets and currents = (MIN_US+MAX_US)/2; enable mask=0; slew=0.
  - Prescaler and µs counter = 0.
- Timing:
  - Prescaler counts 0..CLK_HZ/1e6-1; us_tick pulses on terminal count.
  - us_cnt advances on us_tick over 0..PERIOD_US-1, then wraps to 0.
  - frame_start is asserted in the cycle us_cnt wraps to 0. The first frame_start after reset occurs when the first wrap happens.
- Register map (word addresses):
  - 0..NUM_CH-1: TARGET[ch], bits[15:0], RW. Written value is clamped to [MIN_US,MAX_US]; reads return the clamped value.
  - NUM_CH: ENABLE, bits[NUM_CH-1:0], RW.
  - NUM_CH+1: SLEW, bits[15:0], RW, µs per frame; 0 = jump immediately.
  - NUM_CH+2: STATUS, RO. Bit ch = busy, meaning current[ch] ≠ target[ch]. Bits[31:16] = us_cnt.
  - Unmapped reads return 0; unmapped writes are ignored. Unused high bits read 0.
- Slew update, on each frame_start cycle, per channel:
  - SLEW=0: current ← target.
  - Else current moves toward target by min(SLEW, |target−current|), with no overshoot.
- Output rule: pwm_out[ch] = ENABLE[ch] && (us_cnt < current[ch]). The output is registered, so there is one cycle of latency from us_cnt.
- Boundary conditions:
  - Disabling a channel mid-pulse drives the output low on the next clock. The pulse is truncated, which is accepted.
  - Enabling a channel mid-frame: the output goes high only if us_cnt < current[ch]. It may produce a partial pulse, which is accepted.
  - TARGET write in the same cycle as frame_start: the slew step uses the old target; the new target applies from the next frame.
  - Writes with 0 or out-of-range values are clamped; there is never a pulse below MIN_US or above MAX_US.
  - Reset asserted mid-frame: all outputs go low immediately (asynchronous). After release the frame restarts from us_cnt=0.
- Read and write strobes asserted in the same cycle: the write commits and the read returns the pre-write value.

Decomposition:
- Shared package servo_pkg holds:
  - Constants US_W=16 and DEFAULT_US.
  - Register offset localparams relative to NUM_CH.
  - Function clamp_us(value, MIN_US, MAX_US).
- One natural sub-module, servo_slew_ch, instanced NUM_CH times. It holds target, current and the per-channel output compare. Inputs: frame_start, us_cnt, enable, slew, write port. Outputs: pwm, busy, target.
- Top level holds the prescaler, frame counter and Avalon decode.

Test Plan (use CLK_HZ=2_000_000, PERIOD_US=100, MIN_US=10, MAX_US=90 for sim speed):
- Reset, then ENABLE=0x1, no other writes → ch0 high 50 µs (100 clocks) per 100 µs frame; other channels low.
- Write TARGET0=5 and read it back → reads 10. Write TARGET0=200 → reads 90, and pwm_out[0] high 90 µs per frame.
- SLEW=10, TARGET1=80, ENABLE=0x2 → ch1 widths 60, 70, 80 µs over successive frames. STATUS bit1 =1 until the 80 µs frame, then 0.
- Clear ENABLE bit0 while pwm_out[0] is high → output low on the next clock; the next frame stays low.
- Write TARGET2 in the frame_start cycle with SLEW=0 → that frame uses the old width and the next frame the new width.
- Assert iRST_N low mid-pulse for 3 clocks → pwm_out=0 asynchronously. After release, targets read 50 and the first frame_start arrives 100 µs later.
